snax_tcdm_rw_bank_merger: RTL
=============================

Name: snax_tcdm_rw_bank_merger

Overview:
- Per-bank merge stage between a write-only TCDM interconnect and a read-only TCDM interconnect; both drive the same NumBanks SRAM banks.
- Each cycle, per bank, arbitrates between the write-side and read-side memory requests using a selectable policy with a starvation bound.
- Forwards the winner to the bank and returns read data to the read side after the fixed memory latency.
- Sits directly in front of the TCDM banks, replacing hard-wired dual-interconnect bank sharing.

Parameters:
- NumBanks, 8, number of memory banks (channels), ≥1
- MemAddrWidth, 10, bank-local word address width
- DataWidth, 64, data width; strobe width is DataWidth/8
- MemoryResponseLatency, 1, cycles from accepted read to valid bank data, ≥1
- Policy, 2, 0 = write-priority, 1 = read-priority, 2 = round-robin
- StallLimit, 4, consecutive lost conflicts before forced grant; 0 disables, max 255

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- wr_q_valid_i  in  NumBanks  write request valid per bank
- wr_q_ready_o  out  NumBanks  write request accepted
- wr_q_addr_i  in  NumBanks*MemAddrWidth  write address
- wr_q_data_i  in  NumBanks*DataWidth  write data
- wr_q_strb_i  in  NumBanks*DataWidth/8  byte strobes
- rd_q_valid_i  in  NumBanks  read request valid
- rd_q_ready_o  out  NumBanks  read request accepted
- rd_q_addr_i  in  NumBanks*MemAddrWidth  read address
- rd_p_valid_o  out  NumBanks  read response valid
- rd_p_data_o  out  NumBanks*DataWidth  read response data
- mem_q_valid_o  out  NumBanks  bank request valid
- mem_q_ready_i  in  NumBanks  bank accepts request
- mem_q_addr_o  out  NumBanks*MemAddrWidth  bank address
- mem_q_write_o  out  NumBanks  1 = write
- mem_q_data_o  out  NumBanks*DataWidth  bank write data
- mem_q_strb_o  out  NumBanks*DataWidth/8  bank strobes
- mem_p_data_i  in  NumBanks*DataWidth  bank read data
- perf_conflict_o  out  NumBanks*32  per-bank conflict count

Behaviour:
- Reset (async, rst_i=1):
  - all registered outputs 0; rd_p_valid_o=0
  - round-robin pointer = read-next
  - stall counters 0; lock flags 0; latency pipes cleared
- Banks are fully independent; every rule below applies per bank.
- Request forwarding:
  - mem_q_valid_o = wr_q_valid_i | rd_q_valid_i
  - winner's payload muxed to the bank
  - mem_q_write_o=1 for write winner; data/strb=0 for read winner
- Ready: winner_ready = mem_q_ready_i; loser ready = 0. Combinational, zero latency.
- No conflict (one side valid): that side wins.
- Conflict (both valid) winner, in priority order:
  - (a) locked side, if lock set
  - (b) side whose stall counter == StallLimit, when StallLimit≠0
  - (c) Policy: write, read, or round-robin pointer
- Lock: set when mem_q_valid_o=1 and mem_q_ready_i=0, holding the current winner. Cleared on handshake. Winner and payload stay stable while stalled.
- Round-robin pointer: on each conflict handshake, points to the loser. Non-conflict handshakes leave it unchanged.
- Stall counter (one per side, 8 bit):
  - +1 on a cycle where the side is valid and the other side handshakes
  - cleared when the side handshakes or deasserts valid
  - saturates at StallLimit
  - if both counters are at limit simultaneously, write wins
- Read response:
  - read handshake pushes 1 into a MemoryResponseLatency-deep valid shift register
  - rd_p_valid_o = its tail
  - rd_p_data_o = mem_p_data_i when tail=1, else 0
- Writes produce no response.
- Back-to-back reads every cycle are sustained; throughput is 1 request/bank/cycle.
- Reset mid-operation: in-flight read responses are dropped, lock released, counters cleared.

Optional Feature:
- Macro: SNAX_TCDM_MERGE_PERF_EN.
- Defined: each bank has a 32-bit saturating counter, +1 per cycle with wr_q_valid_i & rd_q_valid_i; driven on perf_conflict_o; cleared by reset.
- Undefined: perf_conflict_o tied to 0, no counter flops.

Test Plan:
- Policy=0, bank 3, wr and rd valid at addr 0x10/0x20, ready=1 for 3 cycles -> write granted all 3 cycles. With StallLimit=2, read is granted on cycle 3; rd_p_valid_o[3]=1 one cycle later.
- Policy=2, both sides always valid on bank 0, ready=1 -> grants alternate R,W,R,W starting with read after reset; perf_conflict_o[0] = 4 after 4 cycles (PERF_EN defined).
- Read granted with mem_q_ready_i=0 for 2 cycles while a write arrives -> read stays locked, mem_q_write_o=0 and addr stable; read handshakes on cycle 3, write on cycle 4.
- MemoryResponseLatency=3, reads issued on cycles 0,1,2 returning 0xA,0xB,0xC -> rd_p_valid_o high on cycles 3,4,5 with matching data.
- Write only to bank 5: data 0xDEADBEEF, strb 0x0F -> mem_q_write_o=1, strobes forwarded, rd_p_valid_o stays 0.
- rst_i asserted one cycle after a read handshake (latency 2) -> no rd_p_valid_o pulse; all outputs 0 during reset.

Source files
------------

// File: rtl/snax_tcdm_rw_bank_merger_if.sv
// Bus bundle between the write/read TCDM interconnects, the merger and the SRAM banks.
// The slave modport is the merger's view; the master modport is the surrounding fabric/banks.
interface snax_tcdm_rw_bank_merger_if #(
   parameter int unsigned NumBanks     = 8,
   parameter int unsigned MemAddrWidth = 10,
   parameter int unsigned DataWidth    = 64
);
   localparam int unsigned StrbWidth = DataWidth / 8;

   logic [NumBanks-1:0]              wr_q_valid_i;
   logic [NumBanks-1:0]              wr_q_ready_o;
   logic [NumBanks*MemAddrWidth-1:0] wr_q_addr_i;
   logic [NumBanks*DataWidth-1:0]    wr_q_data_i;
   logic [NumBanks*StrbWidth-1:0]    wr_q_strb_i;
   logic [NumBanks-1:0]              rd_q_valid_i;
   logic [NumBanks-1:0]              rd_q_ready_o;
   logic [NumBanks*MemAddrWidth-1:0] rd_q_addr_i;
   logic [NumBanks-1:0]              rd_p_valid_o;
   logic [NumBanks*DataWidth-1:0]    rd_p_data_o;
   logic [NumBanks-1:0]              mem_q_valid_o;
   logic [NumBanks-1:0]              mem_q_ready_i;
   logic [NumBanks*MemAddrWidth-1:0] mem_q_addr_o;
   logic [NumBanks-1:0]              mem_q_write_o;
   logic [NumBanks*DataWidth-1:0]    mem_q_data_o;
   logic [NumBanks*StrbWidth-1:0]    mem_q_strb_o;
   logic [NumBanks*DataWidth-1:0]    mem_p_data_i;
   logic [NumBanks*32-1:0]           perf_conflict_o;

   modport slave (
      input  wr_q_valid_i, wr_q_addr_i, wr_q_data_i, wr_q_strb_i,
      input  rd_q_valid_i, rd_q_addr_i, mem_q_ready_i, mem_p_data_i,
      output wr_q_ready_o, rd_q_ready_o, rd_p_valid_o, rd_p_data_o,
      output mem_q_valid_o, mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o,
      output perf_conflict_o
   );

   modport master (
      output wr_q_valid_i, wr_q_addr_i, wr_q_data_i, wr_q_strb_i,
      output rd_q_valid_i, rd_q_addr_i, mem_q_ready_i, mem_p_data_i,
      input  wr_q_ready_o, rd_q_ready_o, rd_p_valid_o, rd_p_data_o,
      input  mem_q_valid_o, mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o,
      input  perf_conflict_o
   );
endinterface

// File: rtl/snax_tcdm_rw_bank_merger.sv
// Per-bank write/read request merger in front of TCDM banks; SNAX_TCDM_MERGE_PERF_EN adds conflict counters.
// Latency: requests pass combinationally; read responses return MemoryResponseLatency cycles after handshake.
// Backpressure: bank ready goes to the winner only; a stalled winner is locked until it handshakes.
module snax_tcdm_rw_bank_merger #(
   parameter int unsigned NumBanks              = 8,
   parameter int unsigned MemAddrWidth          = 10,
   parameter int unsigned DataWidth             = 64,
   parameter int unsigned MemoryResponseLatency = 1,
   parameter int unsigned Policy                = 2,
   parameter int unsigned StallLimit            = 4
) (
   input logic                        clk_i,
   input logic                        rst_i,
   snax_tcdm_rw_bank_merger_if.slave  bus
);
   localparam int unsigned SW    = DataWidth / 8;
   localparam int unsigned Lat   = MemoryResponseLatency;
   localparam logic [7:0]  LIMIT = 8'(StallLimit);

   logic [NumBanks-1:0] w_wr_vld, w_rd_vld, w_conflict, w_sel_rd, w_wr_hs, w_rd_hs;
   logic [NumBanks-1:0] r_lock, r_lock_rd, r_rr_rd;
   logic [7:0]          r_wr_stall [NumBanks];
   logic [7:0]          r_rd_stall [NumBanks];
   logic [Lat-1:0]      r_rd_pipe  [NumBanks];
`ifdef SNAX_TCDM_MERGE_PERF_EN
   logic [31:0]         r_perf     [NumBanks];
`endif

   assign w_wr_vld = bus.wr_q_valid_i;
   assign w_rd_vld = bus.rd_q_valid_i;

   always_comb begin
      w_conflict          = '0;
      w_sel_rd            = '0;
      w_wr_hs             = '0;
      w_rd_hs             = '0;
      bus.wr_q_ready_o    = '0;
      bus.rd_q_ready_o    = '0;
      bus.mem_q_valid_o   = '0;
      bus.mem_q_addr_o    = '0;
      bus.mem_q_write_o   = '0;
      bus.mem_q_data_o    = '0;
      bus.mem_q_strb_o    = '0;
      bus.rd_p_valid_o    = '0;
      bus.rd_p_data_o     = '0;
      bus.perf_conflict_o = '0;
      for (int b = 0; b < NumBanks; b++) begin
         w_conflict[b] = w_wr_vld[b] & w_rd_vld[b];
         // Conflict arbitration: held lock, then starvation bound (write first), then policy.
         if (!w_conflict[b])
            w_sel_rd[b] = w_rd_vld[b];
         else if (r_lock[b])
            w_sel_rd[b] = r_lock_rd[b];
         else if (StallLimit != 0 && r_wr_stall[b] == LIMIT)
            w_sel_rd[b] = 1'b0;
         else if (StallLimit != 0 && r_rd_stall[b] == LIMIT)
            w_sel_rd[b] = 1'b1;
         else if (Policy == 0)
            w_sel_rd[b] = 1'b0;
         else if (Policy == 1)
            w_sel_rd[b] = 1'b1;
         else
            w_sel_rd[b] = r_rr_rd[b];

         bus.mem_q_valid_o[b] = w_wr_vld[b] | w_rd_vld[b];
         bus.wr_q_ready_o[b]  = bus.mem_q_ready_i[b] & ~w_sel_rd[b];
         bus.rd_q_ready_o[b]  = bus.mem_q_ready_i[b] &  w_sel_rd[b];
         w_wr_hs[b]           = w_wr_vld[b] & bus.wr_q_ready_o[b];
         w_rd_hs[b]           = w_rd_vld[b] & bus.rd_q_ready_o[b];

         bus.mem_q_write_o[b] = w_wr_vld[b] & ~w_sel_rd[b];
         bus.mem_q_addr_o[b*MemAddrWidth +: MemAddrWidth] = w_sel_rd[b]
            ? bus.rd_q_addr_i[b*MemAddrWidth +: MemAddrWidth]
            : bus.wr_q_addr_i[b*MemAddrWidth +: MemAddrWidth];
         bus.mem_q_data_o[b*DataWidth +: DataWidth] = w_sel_rd[b] ? '0 : bus.wr_q_data_i[b*DataWidth +: DataWidth];
         bus.mem_q_strb_o[b*SW +: SW]               = w_sel_rd[b] ? '0 : bus.wr_q_strb_i[b*SW +: SW];

         bus.rd_p_valid_o[b] = r_rd_pipe[b][Lat-1];
         bus.rd_p_data_o[b*DataWidth +: DataWidth] = r_rd_pipe[b][Lat-1]
            ? bus.mem_p_data_i[b*DataWidth +: DataWidth] : '0;
`ifdef SNAX_TCDM_MERGE_PERF_EN
         bus.perf_conflict_o[b*32 +: 32] = r_perf[b];
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lock    <= '0;
         r_lock_rd <= '0;
         r_rr_rd   <= '1;
         for (int b = 0; b < NumBanks; b++) begin
            r_wr_stall[b] <= '0;
            r_rd_stall[b] <= '0;
            r_rd_pipe[b]  <= '0;
         end
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            r_lock[b]    <= (w_wr_vld[b] | w_rd_vld[b]) & ~bus.mem_q_ready_i[b];
            r_lock_rd[b] <= w_sel_rd[b];
            if (w_conflict[b] && bus.mem_q_ready_i[b])
               r_rr_rd[b] <= ~w_sel_rd[b];

            if (!w_wr_vld[b] || w_wr_hs[b])
               r_wr_stall[b] <= '0;
            else if (w_rd_hs[b] && r_wr_stall[b] != LIMIT)
               r_wr_stall[b] <= r_wr_stall[b] + 8'd1;

            if (!w_rd_vld[b] || w_rd_hs[b])
               r_rd_stall[b] <= '0;
            else if (w_wr_hs[b] && r_rd_stall[b] != LIMIT)
               r_rd_stall[b] <= r_rd_stall[b] + 8'd1;

            r_rd_pipe[b] <= (r_rd_pipe[b] << 1) | Lat'(w_rd_hs[b]);
         end
      end
   end

`ifdef SNAX_TCDM_MERGE_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < NumBanks; b++) r_perf[b] <= '0;
      end else begin
         for (int b = 0; b < NumBanks; b++)
            if (w_conflict[b] && r_perf[b] != 32'hFFFF_FFFF)
               r_perf[b] <= r_perf[b] + 32'd1;
      end
   end
`endif
endmodule
